sram_cache_ctrl: RTL

- Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
- Cache line = 64 bits (two 32-bit words), matching the SRAM controller's 64-bit burst read.
- Read hits return in the same cycle.
- Read misses, and all writes, sequence one SRAM controller transaction and stall the pipeline through ready.

---
 rtl/sram_cache_ctrl_pkg.sv | 6 +
 rtl/cache_line_store.sv | 36 +++
 rtl/sram_cache_ctrl.sv | 73 +++++++
 3 files changed

// File: rtl/sram_cache_ctrl_pkg.sv
// sram_cache_ctrl_pkg: shared FSM encoding and geometry constants for the data cache.
package sram_cache_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
  localparam int LINE_W = 64;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: valid/tag/data arrays with combinational lookup and synchronous fill/word update.
module cache_line_store import sram_cache_ctrl_pkg::*; #(
  parameter int INDEX_W = 6,
  parameter int TAG_W = 16 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               word_sel,
  input  logic               fill_en,
  input  logic [LINE_W-1:0]  fill_data,
  input  logic               wr_en,
  input  logic [31:0]        wr_data,
  output logic               hit,
  output logic [31:0]        rdata
);
  localparam int LINES = 2 ** INDEX_W;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [LINE_W-1:0] data [LINES];
  assign hit = valid[index] && tags[index] == tag;
  assign rdata = hit ? (word_sel ? data[index][63:32] : data[index][31:0]) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (fill_en) valid[index] <= 1'b1;
  // Only valid bits need reset; tags/data are qualified by them.
  always_ff @(posedge clk)
    if (fill_en) begin
      tags[index] <= tag;
      data[index] <= fill_data;
    end else if (wr_en) begin
      if (word_sel) data[index][63:32] <= wr_data;
      else data[index][31:0] <= wr_data;
    end
endmodule

// File: rtl/sram_cache_ctrl.sv
// sram_cache_ctrl: direct-mapped write-through no-write-allocate cache in front of the SRAM controller.
// Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module sram_cache_ctrl import sram_cache_ctrl_pkg::*; #(
  parameter int          INDEX_W   = 6,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_W = 16 - INDEX_W;
  state_t state;
  logic [31:0] a;
  logic hit, fill_en, wr_en, unused_addr;
  assign a = address - BASE_ADDR;
  assign unused_addr = ^{a[31:19], a[1:0]};
  assign fill_en = state == FILL && sram_ready;
  assign wr_en = state == IDLE && mem_w_en && hit;
  assign sram_r_en = state == FILL;
  assign sram_w_en = state == WRITE;
  assign sram_addr = address;
  assign sram_wdata = wdata;
  // IDLE must freeze the pipeline in the same cycle it decides to start a transaction.
  assign ready = state == DONE || (state == IDLE && !mem_w_en && !(mem_r_en && !hit));
  cache_line_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_store (
    .clk      (clk),
    .rst      (rst),
    .index    (a[INDEX_W+2:3]),
    .tag      (a[18:INDEX_W+3]),
    .word_sel (a[2]),
    .fill_en  (fill_en),
    .fill_data(sram_rdata),
    .wr_en    (wr_en),
    .wr_data  (wdata),
    .hit      (hit),
    .rdata    (rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else
      case (state)
        IDLE:    state <= mem_w_en ? WRITE : (mem_r_en && !hit) ? FILL : IDLE;
        FILL:    state <= sram_ready ? IDLE : FILL;
        WRITE:   state <= sram_ready ? DONE : WRITE;
        default: state <= IDLE;
      endcase
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_count <= '0;
      miss_count <= '0;
    end else if (state == IDLE && mem_r_en && !mem_w_en) begin
      if (hit) hit_count <= hit_count + 32'd1;
      else miss_count <= miss_count + 32'd1;
    end
`endif
endmodule
